// File: rtl/pipeline_hazard_scoreboard_pkg.sv
// Shared types and constants for the hazard/forwarding scoreboard: entry layout,
// forward-select encoding and flush FSM states.
package pipeline_hazard_scoreboard_pkg;

  // Entries carry a fixed-width rd so the struct stays parameter-free; REG_AW must not exceed this.
  localparam int REG_AW_MAX = 8;
  localparam int FWD_RF     = 0;
  localparam int STAGE_EX   = 1;

  typedef struct packed {
    logic                  valid;
    logic [REG_AW_MAX-1:0] rd;
    logic                  regwrite;
    logic                  memread;
  } sb_entry_t;

  typedef enum logic {
    FL_IDLE   = 1'b0,
    FL_SQUASH = 1'b1
  } flush_state_t;

  function automatic int fwd_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipeline_hazard_scoreboard_if.sv
// Decode-side bundle between the pipeline control and the hazard scoreboard.
// id_valid qualifies the ID fields every cycle; an instruction leaves ID on any cycle with stall=0.
interface pipeline_hazard_scoreboard_if #(
  parameter int REG_AW = 4,
  parameter int FWD_W  = 2,
  parameter int CNT_W  = 16
);
  logic              id_valid;
  logic [REG_AW-1:0] id_rs1;
  logic              id_rs1_used;
  logic [REG_AW-1:0] id_rs2;
  logic              id_rs2_used;
  logic [REG_AW-1:0] id_rd;
  logic              id_regwrite;
  logic              id_memread;
  logic              ex_branch_taken;
  logic              stall;
  logic              flush;
  logic [FWD_W-1:0]  fwd_a;
  logic [FWD_W-1:0]  fwd_b;
  logic [CNT_W-1:0]  stall_count;
  logic [CNT_W-1:0]  flush_count;

  modport master (
    output id_valid, id_rs1, id_rs1_used, id_rs2, id_rs2_used, id_rd,
    output id_regwrite, id_memread, ex_branch_taken,
    input  stall, flush, fwd_a, fwd_b, stall_count, flush_count
  );

  modport slave (
    input  id_valid, id_rs1, id_rs1_used, id_rs2, id_rs2_used, id_rd,
    input  id_regwrite, id_memread, ex_branch_taken,
    output stall, flush, fwd_a, fwd_b, stall_count, flush_count
  );
endinterface

// File: rtl/pipeline_hazard_scoreboard_operand_forward_match.sv
// Per-operand priority match over the in-flight entries: youngest producer wins,
// and a load still inside its latency window becomes a load-use hazard instead of a forward.
module operand_forward_match
  import pipeline_hazard_scoreboard_pkg::*;
#(
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 1,
  parameter int R0_ZERO  = 1,
  parameter int REG_AW   = 4,
  parameter int FWD_W    = 2
) (
  input  sb_entry_t [DEPTH-1:0] entries,
  input  logic                  id_valid,
  input  logic                  used,
  input  logic [REG_AW-1:0]     rs,
  output logic [FWD_W-1:0]      fwd,
  output logic                  hazard
);

  logic             qualify;
  logic             hit;
  logic             win_load;
  logic [FWD_W-1:0] win_k;

  assign qualify = id_valid & used & ~((R0_ZERO != 0) && (rs == '0));

  // Scan oldest to youngest so the last hit (lowest stage) takes priority.
  always_comb begin
    hit      = 1'b0;
    win_load = 1'b0;
    win_k    = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (entries[k-1].valid && entries[k-1].regwrite &&
          (entries[k-1].rd == REG_AW_MAX'(rs))) begin
        hit      = 1'b1;
        win_load = entries[k-1].memread;
        win_k    = FWD_W'(k);
      end
    end
  end

  always_comb begin
    hazard = qualify & hit & win_load & (int'(win_k) <= LOAD_LAT);
    fwd    = FWD_W'(FWD_RF);
    if (qualify && hit && !hazard) fwd = win_k;
  end

endmodule

// File: rtl/pipeline_hazard_scoreboard.sv
// Hazard and forwarding controller: in-flight destination shift register, flush FSM,
// per-operand forward selects and saturating stall/flush event counters.
module pipeline_hazard_scoreboard
  import pipeline_hazard_scoreboard_pkg::*;
#(
  parameter int REG_AW    = 4,
  parameter int DEPTH     = 3,
  parameter int LOAD_LAT  = 1,
  parameter int FLUSH_CYC = 1,
  parameter int R0_ZERO   = 1,
  parameter int CNT_W     = 16
) (
  input  logic                          clock,
  input  logic                          rst,
  pipeline_hazard_scoreboard_if.slave   bus,
  output flush_state_t                  dbg_flush_state
);

  localparam int FWD_W = fwd_width(DEPTH);
  localparam int SQ_W  = $clog2(FLUSH_CYC + 1);

  sb_entry_t [DEPTH-1:0] entries;
  sb_entry_t             new_entry;
  flush_state_t          state, state_n;
  logic [SQ_W-1:0]       sq_cnt, sq_cnt_n;
  logic                  flush, stall, accept;
  logic                  haz_a, haz_b;
  logic [FWD_W-1:0]      fwd_a, fwd_b;
  logic [CNT_W-1:0]      stall_count, flush_count;

  operand_forward_match #(
    .DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT), .R0_ZERO(R0_ZERO), .REG_AW(REG_AW), .FWD_W(FWD_W)
  ) u_match_a (
    .entries(entries), .id_valid(bus.id_valid), .used(bus.id_rs1_used),
    .rs(bus.id_rs1), .fwd(fwd_a), .hazard(haz_a)
  );

  operand_forward_match #(
    .DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT), .R0_ZERO(R0_ZERO), .REG_AW(REG_AW), .FWD_W(FWD_W)
  ) u_match_b (
    .entries(entries), .id_valid(bus.id_valid), .used(bus.id_rs2_used),
    .rs(bus.id_rs2), .fwd(fwd_b), .hazard(haz_b)
  );

  // Flush takes precedence over a load-use stall; the branch squashes the dependent anyway.
  assign stall = (haz_a | haz_b) & ~flush;

  always_comb begin
    new_entry = '0;
    if (!(stall || flush)) begin
      new_entry.valid    = bus.id_valid;
      new_entry.rd       = REG_AW_MAX'(bus.id_rd);
      new_entry.regwrite = bus.id_regwrite & bus.id_valid;
      new_entry.memread  = bus.id_memread & bus.id_valid;
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) entries <= '0;
    else     entries <= {entries[DEPTH-2:0], new_entry};
  end

  always_comb begin
    state_n  = state;
    sq_cnt_n = sq_cnt;
    flush    = 1'b0;
    accept   = 1'b0;
    case (state)
      FL_IDLE: begin
        if (bus.ex_branch_taken) begin
          flush  = 1'b1;
          accept = 1'b1;
          if (FLUSH_CYC > 1) begin
            state_n  = FL_SQUASH;
            sq_cnt_n = SQ_W'(FLUSH_CYC - 1);
          end
        end
      end
      FL_SQUASH: begin
        flush = 1'b1;
        if (sq_cnt <= SQ_W'(1)) begin
          state_n  = FL_IDLE;
          sq_cnt_n = '0;
        end else begin
          sq_cnt_n = sq_cnt - 1'b1;
        end
      end
      default: state_n = FL_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state  <= FL_IDLE;
      sq_cnt <= '0;
    end else begin
      state  <= state_n;
      sq_cnt <= sq_cnt_n;
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (stall && (stall_count != '1))  stall_count <= stall_count + 1'b1;
      if (accept && (flush_count != '1)) flush_count <= flush_count + 1'b1;
    end
  end

  assign bus.stall       = stall;
  assign bus.flush       = flush;
  assign bus.fwd_a       = fwd_a;
  assign bus.fwd_b       = fwd_b;
  assign bus.stall_count = stall_count;
  assign bus.flush_count = flush_count;
  assign dbg_flush_state = state;

endmodule

// File: tb/tb_pipeline_hazard_scoreboard.sv
// Bench for pipeline_hazard_scoreboard: a default instance and a FLUSH_CYC=2 / CNT_W=2 instance
// share one stimulus stream; directed scenarios plus a random run against a history-based model.
module tb_pipeline_hazard_scoreboard;
  import pipeline_hazard_scoreboard_pkg::*;

  logic clock = 1'b0;
  logic rst   = 1'b1;
  always #5 clock = ~clock;

  logic       t_valid, t_u1, t_u2, t_rw, t_mr, t_br;
  logic [3:0] t_rs1, t_rs2, t_rd;

  int n_checks = 0;
  int n_fail   = 0;

  pipeline_hazard_scoreboard_if #(.REG_AW(4), .FWD_W(2), .CNT_W(16)) if0 ();
  pipeline_hazard_scoreboard_if #(.REG_AW(4), .FWD_W(2), .CNT_W(2))  if1 ();
  flush_state_t dbg0, dbg1;

  assign if0.id_valid = t_valid;  assign if1.id_valid = t_valid;
  assign if0.id_rs1 = t_rs1;      assign if1.id_rs1 = t_rs1;
  assign if0.id_rs1_used = t_u1;  assign if1.id_rs1_used = t_u1;
  assign if0.id_rs2 = t_rs2;      assign if1.id_rs2 = t_rs2;
  assign if0.id_rs2_used = t_u2;  assign if1.id_rs2_used = t_u2;
  assign if0.id_rd = t_rd;        assign if1.id_rd = t_rd;
  assign if0.id_regwrite = t_rw;  assign if1.id_regwrite = t_rw;
  assign if0.id_memread = t_mr;   assign if1.id_memread = t_mr;
  assign if0.ex_branch_taken = t_br;
  assign if1.ex_branch_taken = t_br;

  pipeline_hazard_scoreboard #(
    .REG_AW(4), .DEPTH(3), .LOAD_LAT(1), .FLUSH_CYC(1), .R0_ZERO(1), .CNT_W(16)
  ) dut0 (.clock(clock), .rst(rst), .bus(if0.slave), .dbg_flush_state(dbg0));

  pipeline_hazard_scoreboard #(
    .REG_AW(4), .DEPTH(3), .LOAD_LAT(1), .FLUSH_CYC(2), .R0_ZERO(1), .CNT_W(2)
  ) dut1 (.clock(clock), .rst(rst), .bus(if1.slave), .dbg_flush_state(dbg1));

  // Reference model: last three issued instructions by age, flush cycles left, event counts.
  typedef struct { bit v; int rd; bit rw; bit mr; } m_ent_t;
  localparam int LOAD_LAT = 1;
  localparam int FC   [2] = '{1, 2};
  localparam int CMAX [2] = '{65535, 3};
  m_ent_t mh [0:1][1:3];
  int m_fl [2];
  int m_sc [2];
  int m_fc [2];
  logic [5:0] exp_q [$];

  task automatic m_reset();
    for (int c = 0; c < 2; c++) begin
      for (int k = 1; k <= 3; k++) mh[c][k] = '{0, 0, 0, 0};
      m_fl[c] = 0; m_sc[c] = 0; m_fc[c] = 0;
    end
  endtask

  function automatic int m_fwd(int c, bit used, int rs, output bit haz);
    haz = 0;
    if (!t_valid || !used || rs == 0) return 0;
    for (int k = 1; k <= 3; k++) begin
      if (mh[c][k].v && mh[c][k].rw && mh[c][k].rd == rs) begin
        if (mh[c][k].mr && k <= LOAD_LAT) begin
          haz = 1;
          return 0;
        end
        return k;
      end
    end
    return 0;
  endfunction

  task automatic set_id(input logic v, input logic [3:0] rs1, input logic u1, input logic [3:0] rs2,
                        input logic u2, input logic [3:0] rd, input logic rw, input logic mr);
    t_valid = v; t_rs1 = rs1; t_u1 = u1; t_rs2 = rs2; t_u2 = u2;
    t_rd = rd; t_rw = rw; t_mr = mr;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    t_br = 0;
    rst  = 1;
    tick();
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clock);
    n_checks++; if (if0.stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got=%b exp=0", if0.stall); end
    n_checks++; if (if0.flush !== 1'b0) begin n_fail++; $display("FAIL reset_flush got=%b exp=0", if0.flush); end
    n_checks++; if (if0.fwd_a !== 2'd0 || if0.fwd_b !== 2'd0) begin n_fail++; $display("FAIL reset_fwd got=%0d/%0d exp=0/0", if0.fwd_a, if0.fwd_b); end
    n_checks++; if (if0.stall_count !== 16'd0 || if0.flush_count !== 16'd0) begin n_fail++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", if0.stall_count, if0.flush_count); end
    n_checks++; if (dbg1 !== FL_IDLE) begin n_fail++; $display("FAIL reset_state got=%0d exp=%0d", dbg1, FL_IDLE); end
    tick();
  endtask

  task automatic test_alu_chain();
    do_reset();
    set_id(1, 0, 0, 0, 0, 3, 1, 0);
    @(negedge clock);
    n_checks++; if (if0.fwd_a !== 2'd0 || if0.stall !== 1'b0) begin n_fail++; $display("FAIL chain_c0 got fwd_a=%0d stall=%b exp 0/0", if0.fwd_a, if0.stall); end
    tick();
    set_id(1, 3, 1, 0, 0, 7, 0, 0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clock);
      n_checks++;
      if (if0.fwd_a !== 2'(k) || if0.stall !== 1'b0) begin
        n_fail++; $display("FAIL chain_stage%0d got fwd_a=%0d stall=%b exp fwd_a=%0d stall=0", k, if0.fwd_a, if0.stall, k);
      end
      tick();
    end
    @(negedge clock);
    n_checks++; if (if0.fwd_a !== 2'd0) begin n_fail++; $display("FAIL chain_retired got fwd_a=%0d exp=0", if0.fwd_a); end
    tick();
  endtask

  task automatic test_load_use();
    do_reset();
    set_id(1, 0, 0, 0, 0, 5, 1, 1);
    tick();
    set_id(1, 0, 0, 5, 1, 6, 1, 0);
    @(negedge clock);
    n_checks++; if (if0.stall !== 1'b1 || if0.fwd_b !== 2'd0) begin n_fail++; $display("FAIL loaduse_stall got stall=%b fwd_b=%0d exp 1/0", if0.stall, if0.fwd_b); end
    tick();
    @(negedge clock);
    n_checks++; if (if0.stall_count !== 16'd1) begin n_fail++; $display("FAIL loaduse_count got=%0d exp=1", if0.stall_count); end
    n_checks++; if (if0.stall !== 1'b0 || if0.fwd_b !== 2'd2) begin n_fail++; $display("FAIL loaduse_fwd got stall=%b fwd_b=%0d exp 0/2", if0.stall, if0.fwd_b); end
    tick();
  endtask

  task automatic test_priority_r0();
    do_reset();
    set_id(1, 0, 0, 0, 0, 2, 1, 0);
    tick();
    tick();
    set_id(1, 2, 1, 0, 0, 9, 0, 0);
    @(negedge clock);
    n_checks++; if (if0.fwd_a !== 2'd1) begin n_fail++; $display("FAIL priority got fwd_a=%0d exp=1", if0.fwd_a); end
    tick();
    set_id(1, 0, 0, 0, 0, 0, 1, 1);
    tick();
    set_id(1, 0, 1, 0, 1, 4, 1, 0);
    @(negedge clock);
    n_checks++; if (if0.fwd_a !== 2'd0 || if0.stall !== 1'b0) begin n_fail++; $display("FAIL r0 got fwd_a=%0d stall=%b exp 0/0", if0.fwd_a, if0.stall); end
    tick();
  endtask

  task automatic test_branch_vs_stall();
    do_reset();
    set_id(1, 0, 0, 0, 0, 5, 1, 1);
    tick();
    set_id(1, 0, 0, 5, 1, 6, 1, 0);
    t_br = 1;
    @(negedge clock);
    n_checks++; if (if0.flush !== 1'b1 || if0.stall !== 1'b0) begin n_fail++; $display("FAIL br_c1_d0 got flush=%b stall=%b exp 1/0", if0.flush, if0.stall); end
    n_checks++; if (if1.flush !== 1'b1 || if1.stall !== 1'b0) begin n_fail++; $display("FAIL br_c1_d1 got flush=%b stall=%b exp 1/0", if1.flush, if1.stall); end
    tick();
    @(negedge clock);
    n_checks++; if (if0.flush_count !== 16'd1 || if1.flush_count !== 2'd1) begin n_fail++; $display("FAIL br_count got=%0d/%0d exp=1/1", if0.flush_count, if1.flush_count); end
    n_checks++; if (if1.flush !== 1'b1 || dbg1 !== FL_SQUASH) begin n_fail++; $display("FAIL br_squash got flush=%b state=%0d exp 1/%0d", if1.flush, dbg1, FL_SQUASH); end
    tick();
    t_br = 0;
    @(negedge clock);
    n_checks++; if (if0.flush_count !== 16'd2 || if1.flush_count !== 2'd1) begin n_fail++; $display("FAIL br_ignored got=%0d/%0d exp=2/1", if0.flush_count, if1.flush_count); end
    n_checks++; if (if0.flush !== 1'b0 || if1.flush !== 1'b0) begin n_fail++; $display("FAIL br_end got=%b/%b exp=0/0", if0.flush, if1.flush); end
    n_checks++; if (if0.fwd_b !== 2'd3 || if0.stall !== 1'b0) begin n_fail++; $display("FAIL br_bubbles got fwd_b=%0d stall=%b exp 3/0", if0.fwd_b, if0.stall); end
    tick();
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    set_id(1, 0, 0, 0, 0, 4, 1, 0);
    tick();
    set_id(1, 0, 0, 0, 0, 6, 1, 0);
    t_br = 1;
    tick();
    t_br = 0;
    set_id(1, 4, 1, 4, 1, 7, 1, 0);
    #2;
    n_checks++; if (if1.flush !== 1'b1 || if0.fwd_a !== 2'd2) begin n_fail++; $display("FAIL mid_pre got flush=%b fwd_a=%0d exp 1/2", if1.flush, if0.fwd_a); end
    rst = 1;
    #1;
    n_checks++; if ({if0.stall, if0.flush, if0.fwd_a, if0.fwd_b} !== 6'd0 || {if1.stall, if1.flush, if1.fwd_a, if1.fwd_b} !== 6'd0) begin
      n_fail++; $display("FAIL mid_async got d0=%b d1=%b exp all 0", {if0.stall, if0.flush, if0.fwd_a, if0.fwd_b}, {if1.stall, if1.flush, if1.fwd_a, if1.fwd_b}); end
    n_checks++; if (if0.flush_count !== 16'd0 || if1.flush_count !== 2'd0 || dbg1 !== FL_IDLE) begin
      n_fail++; $display("FAIL mid_async_state got cnt=%0d/%0d state=%0d exp 0/0/0", if0.flush_count, if1.flush_count, dbg1); end
    #1;
    rst = 0;
    @(negedge clock);
    n_checks++; if (if0.fwd_a !== 2'd0 || if1.flush !== 1'b0) begin n_fail++; $display("FAIL mid_after got fwd_a=%0d flush=%b exp 0/0", if0.fwd_a, if1.flush); end
    tick();
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_id(1, 0, 0, 0, 0, 5, 1, 1);
      tick();
      set_id(1, 0, 0, 5, 1, 8, 1, 0);
      tick();
      tick();
    end
    @(negedge clock);
    n_checks++; if (if0.stall_count !== 16'd5) begin n_fail++; $display("FAIL sat_wide got=%0d exp=5", if0.stall_count); end
    n_checks++; if (if1.stall_count !== 2'd3) begin n_fail++; $display("FAIL sat_narrow got=%0d exp=3", if1.stall_count); end
    tick();
  endtask

  task automatic test_random();
    do_reset();
    m_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      set_id(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             4'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0));
      t_br = ($urandom_range(0, 7) == 0);
      @(negedge clock);
      for (int c = 0; c < 2; c++) begin
        bit ha, hb, e_fl, e_st;
        int e_fa, e_fb;
        logic [5:0] got;
        e_fa = m_fwd(c, t_u1, int'(t_rs1), ha);
        e_fb = m_fwd(c, t_u2, int'(t_rs2), hb);
        e_fl = (m_fl[c] > 0) || t_br;
        e_st = (ha || hb) && !e_fl;
        exp_q.push_back({e_st, e_fl, 2'(e_fa), 2'(e_fb)});
        got = (c == 0) ? {if0.stall, if0.flush, if0.fwd_a, if0.fwd_b} : {if1.stall, if1.flush, if1.fwd_a, if1.fwd_b};
        n_checks++;
        if (got !== exp_q[0]) begin
          n_fail++; $display("FAIL rand_outputs dut%0d cyc=%0d got=%b exp=%b (stall,flush,fwd_a,fwd_b)", c, cyc, got, exp_q[0]);
        end
        void'(exp_q.pop_front());
        n_checks++;
        if ((c == 0 ? int'(if0.stall_count) : int'(if1.stall_count)) != m_sc[c] ||
            (c == 0 ? int'(if0.flush_count) : int'(if1.flush_count)) != m_fc[c]) begin
          n_fail++; $display("FAIL rand_counts dut%0d cyc=%0d got=%0d/%0d exp=%0d/%0d", c, cyc,
            (c == 0 ? int'(if0.stall_count) : int'(if1.stall_count)),
            (c == 0 ? int'(if0.flush_count) : int'(if1.flush_count)), m_sc[c], m_fc[c]);
        end
        if (e_st && m_sc[c] < CMAX[c]) m_sc[c]++;
        if (m_fl[c] > 0) m_fl[c]--;
        else if (t_br) begin
          m_fl[c] = FC[c] - 1;
          if (m_fc[c] < CMAX[c]) m_fc[c]++;
        end
        mh[c][3] = mh[c][2];
        mh[c][2] = mh[c][1];
        if (e_st || e_fl) mh[c][1] = '{0, 0, 0, 0};
        else mh[c][1] = '{t_valid, int'(t_rd), t_rw && t_valid, t_mr && t_valid};
      end
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    t_br = 0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    test_reset();
    test_alu_chain();
    test_load_use();
    test_priority_r0();
    test_branch_vs_stall();
    test_reset_mid_op();
    test_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
